// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e     : encoding of the 3-bit Op input
//   - latency defaults for multiply and divide busy periods
//   - CNT_W       : width of the latency counter (covers up to 15 cycles)
//   - md_abs      : two's-complement magnitude of a 32-bit word
package md_pkg;

  localparam int CNT_W            = 4;
  localparam int MULT_CYCLES_DEF  = 5;
  localparam int DIV_CYCLES_DEF   = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  // Magnitude as an unsigned 32-bit value; 0x80000000 maps to itself,
  // which is exactly its magnitude when read as unsigned.
  function automatic logic [31:0] md_abs(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_unit_div.sv
// md_unit_div: combinational 32-bit divider with MIPS sign rules.
//   a_i      : dividend
//   b_i      : divisor (zero yields quo_o = rem_o = 0; caller suppresses the write)
//   signed_i : 1 = div (signed), 0 = divu
//   quo_o    : quotient, truncated toward zero
//   rem_o    : remainder, same sign as the dividend
// Division is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
// instead of hitting a signed-overflow corner of the / operator.
module md_unit_div
  import md_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    ua    = signed_i ? md_abs(a_i) : a_i;
    ub    = signed_i ? md_abs(b_i) : b_i;
    uq    = 32'd0;
    ur    = 32'd0;
    if (ub != 32'd0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    neg_q = signed_i && (a_i[31] ^ b_i[31]);
    neg_r = signed_i && a_i[31];
    quo_o = neg_q ? (~uq + 32'd1) : uq;
    rem_o = neg_r ? (~ur + 32'd1) : ur;
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with the HI/LO registers.
//   Clk   : clock, rising edge
//   Reset : asynchronous active-high reset, clears everything
//   Start : one-cycle pulse, md instruction valid in EX
//   Op    : 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   A, B  : rs / rt operands
//   Busy  : operation in flight, HI/LO not yet updated
//   HI,LO : architectural HI/LO registers (registered outputs)
// The result is computed combinationally at the Start edge and parked in
// PHI/PLO; the counter only models the latency seen by the pipeline.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  logic [31:0]      hi_q,  hi_d;
  logic [31:0]      lo_q,  lo_d;
  logic [31:0]      phi_q, phi_d;
  logic [31:0]      plo_q, plo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             pwr_q, pwr_d;   // pending result gets committed at completion

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo;
  logic [31:0] rem;
  md_op_e      op;

  assign op = md_op_e'(Op);

  // Signed product: low 64 bits of the sign-extended operands' product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  md_unit_div u_div (
    .a_i      (A),
    .b_i      (B),
    .signed_i (op == MD_DIV),
    .quo_o    (quo),
    .rem_o    (rem)
  );

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    pwr_d  = pwr_q;

    if (busy_q) begin
      // Any Start while busy is dropped; only the countdown advances.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
        busy_d = 1'b0;
        pwr_d  = 1'b0;
        if (pwr_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end
    end else if (Start) begin
      case (op)
        MD_MULT, MD_MULTU: begin
          phi_d  = (op == MD_MULT) ? prod_s[63:32] : prod_u[63:32];
          plo_d  = (op == MD_MULT) ? prod_s[31:0]  : prod_u[31:0];
          cnt_d  = MULT_CNT;
          busy_d = 1'b1;
          pwr_d  = 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          phi_d  = rem;
          plo_d  = quo;
          cnt_d  = DIV_CNT;
          busy_d = 1'b1;
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          pwr_d  = (B != 32'd0);
        end
        MD_MTHI: hi_d = A;
        MD_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      phi_q  <= 32'd0;
      plo_q  <= 32'd0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      pwr_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      pwr_q  <= pwr_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit. Directed cases plus a
// randomized sequence checked against an arithmetic reference model of HI/LO.
module tb_md_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: what HI/LO become after an op completes (wr=0: unchanged).
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic wr, output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    wr = 1'b1; h = 32'd0; l = 32'd0;
    case (op)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      3'd2: if (b == 0) wr = 1'b0; else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      3'd3: if (b == 0) wr = 1'b0; else begin q = ua / ub; r = ua % ub; h = r[31:0]; l = q[31:0]; end
      default: wr = 1'b0;
    endcase
  endtask

  function automatic int latency(input logic [2:0] op);
    if (op <= 3'd1) return 5;
    if (op <= 3'd3) return 10;
    return 0;
  endfunction

  // Present a one-cycle Start; returns 1ns after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0; A = 32'h0; B = 32'h0;
  endtask

  // Count remaining busy cycles (bounded).
  task automatic wait_idle(input string tag, input int exp_n);
    int n;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      @(posedge Clk);
      #1;
    end
    check(tag, 64'(n), 64'(exp_n));
  endtask

  // Issue an op with model update and full latency/result checking.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic wr;
    logic [31:0] h, l;
    model(op, a, b, wr, h, l);
    issue(op, a, b);
    if (op == 3'd4) ref_hi = a;
    else if (op == 3'd5) ref_lo = a;
    else if (wr) begin ref_hi = h; ref_lo = l; end
    if (latency(op) == 0) check({tag, "_busy"}, 64'(Busy), 64'd0);
    else wait_idle({tag, "_lat"}, latency(op));
    check({tag, "_hi"}, 64'(HI), 64'(ref_hi));
    check({tag, "_lo"}, 64'(LO), 64'(ref_lo));
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 3'd7; A = 32'h0; B = 32'h0;
    ref_hi = 32'h0; ref_lo = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Reset in the middle of a mult: clears immediately, no late write.
    run_op("seed_hi", 3'd4, 32'h55, 32'h0);
    issue(3'd0, 32'd1000, 32'd1000);
    repeat (2) @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("arst_busy", 64'(Busy), 64'd0);
    check("arst_hi", 64'(HI), 64'd0);
    check("arst_lo", 64'(LO), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    ref_hi = 32'h0; ref_lo = 32'h0;
    repeat (8) @(posedge Clk);
    #1;
    check("arst_late_busy", 64'(Busy), 64'd0);
    check("arst_late_lo", 64'(LO), 64'd0);

    // Directed arithmetic with hand-computed values.
    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3);
    check("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3);
    check("multu_const", {HI, LO}, 64'h00000002_FFFFFFFA);
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2);
    check("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu", 3'd3, 32'd7, 32'd2);
    check("divu_const", {HI, LO}, 64'h00000001_00000003);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_const", {HI, LO}, 64'h00000000_80000000);

    // Seed via mthi/mtlo, then divide by zero keeps them.
    run_op("mthi", 3'd4, 32'h11, 32'h0);
    run_op("mtlo", 3'd5, 32'h22, 32'h0);
    run_op("div0", 3'd2, 32'd1234, 32'd0);
    check("div0_const", {HI, LO}, 64'h00000011_00000022);
    run_op("nop6", 3'd6, 32'hABCD, 32'd1);

    // Start during busy is ignored.
    issue(3'd0, 32'd3, 32'd4);
    issue(3'd5, 32'hDEAD, 32'd0);
    wait_idle("ign_lat", 4);
    check("ign_hilo", {HI, LO}, 64'h00000000_0000000C);
    ref_hi = 32'd0; ref_lo = 32'd12;

    // Back-to-back: divu accepted in first idle cycle after mult.
    run_op("b2b_mult", 3'd1, 32'd6, 32'd7);
    run_op("b2b_divu", 3'd3, 32'd100, 32'd7);
    check("b2b_const", {HI, LO}, 64'h00000002_0000000E);

    // Randomized sequence against the model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      if (rop <= 3'd3 && $urandom_range(0, 2) == 0) begin
        // Inject an illegal Start mid-operation; it must not disturb anything.
        logic wr;
        logic [31:0] h, l;
        model(rop, ra, rb, wr, h, l);
        issue(rop, ra, rb);
        issue(3'($urandom_range(0, 7)), $urandom, $urandom);
        if (wr) begin ref_hi = h; ref_lo = l; end
        wait_idle("rnd_ign_lat", latency(rop) - 1);
        check("rnd_ign_hi", 64'(HI), 64'(ref_hi));
        check("rnd_ign_lo", 64'(LO), 64'(ref_lo));
      end else begin
        run_op("rnd", rop, ra, rb);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo.
- Owns the HI/LO registers and answers stall requests with a Busy signal. The hazard/pause logic consumes Busy to freeze F/D and clear E for md-dependent instructions (mfhi, mflo and further md ops).
- Busy asserts as a consequence of Start; this block is the responder end of that stall handshake.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high after a mult/multu start.
- DIV_CYCLES, 10, cycles Busy stays high after a div/divu start.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  EX-stage md instruction valid this cycle (one-cycle pulse per instruction).
- Op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-op.
- A  input  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- B  input  32  rt operand (divisor / multiplier).
- Busy  output  1  operation in flight; HI/LO not yet valid.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, Busy=0, counter=0, pending results=0. Any in-flight operation is discarded.
- Idle (Busy=0), Start=1, Op in {0..3}, at edge T:
  - compute result into pending regs PHI/PLO;
  - load counter with MULT_CYCLES (Op 0,1) or DIV_CYCLES (Op 2,3);
  - Busy=1 from after T.
- Busy state:
  - counter decrements each edge.
  - On the edge where the counter goes 1->0: HI<=PHI, LO<=PLO, Busy<=0.
  - Busy is therefore high for exactly N cycles (N = 5 or 10). New HI/LO are visible in the first cycle Busy is low.
- mult: {HI,LO} = signed(A) * signed(B), 64-bit.
- multu: {HI,LO} = unsigned 64-bit product.
- div (signed):
  - LO = quotient, truncated toward zero;
  - HI = remainder, taking the sign of the dividend.
  - Example: -7/2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (B=0, Op 2 or 3): full DIV_CYCLES busy period; HI/LO keep their previous values at completion.
- mthi/mtlo with Start=1 while idle: HI<=A (or LO<=A) at the same edge; Busy stays 0. Zero-cycle latency to the next instruction.
- Start=1 while Busy=1: ignored entirely (all ops, including mthi/mtlo). The pause unit guarantees this never happens legally; the bench checks that it is ignored.
- Op 6/7 with Start=1: no effect.
- Start=0: no state change except the counter/completion logic.
- Back-to-back: Start may be accepted in the first cycle after Busy falls. The operands then see updated HI/LO only through mthi/mtlo semantics; there are no read-modify-write ops.
- Outputs HI, LO and Busy are direct register outputs with no combinational path from inputs.

Decomposition:
- Package md_pkg:
  - Op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - default latency constants;
  - counter width (4 bits, enough for DIV_CYCLES up to 15).
- No sub-module required. Product and quotient are computed combinationally at the Start edge and held in PHI/PLO; the counter only models latency.
- An optional md_div_core (signed/unsigned wrapper around / and %) may isolate the sign correction.

Test Plan:
- Reset mid-mult (Reset pulse 2 cycles after Start) -> Busy=0, HI=LO=0 immediately (async); no later write.
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7, B=2 -> Busy high exactly 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- Seed HI=0x11, LO=0x22 via mthi/mtlo (Busy stays 0; values visible the next cycle); then div by B=0 -> 10 busy cycles, HI=0x11, LO=0x22 unchanged.
- mult A=3, B=4 started; during Busy issue Start with Op=mtlo, A=0xDEAD -> ignored; final LO=12, HI=0.
- Start with divu 100/7 in the first idle cycle after a mult completes -> accepted; Busy 10 cycles; LO=14, HI=2.
